// File: rtl/uart_pkg.sv
// uart_pkg: shared types and sizing helpers for the UART transmit arbiter
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, SEND, GAP} arb_state_t;
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at i_ptr, optionally restricted to one index
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_mask_en,
    input  logic [IDX_W-1:0] i_mask_idx,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant_onehot,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] k;
    always_comb begin
        cand = i_mask_en ? (i_req & (N_REQ'(1) << i_mask_idx)) : i_req;
        o_grant_onehot = '0;
        o_grant_idx = '0;
        o_any = 1'b0;
        k = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && cand[k]) begin
                o_any = 1'b1;
                o_grant_idx = k;
                o_grant_onehot[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX between N_REQ byte requesters with round-robin,
// packet lock, inter-frame gap and a send watchdog
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 20000,
    localparam int IDX_W = clog2_min1(N_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_aresetn,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]             i_req_last,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic                         o_tx_start,
    output logic [UART_DATA_W-1:0]       o_tx_data,
    input  logic                         i_tx_done,
    output logic                         o_busy,
    output logic [IDX_W-1:0]             o_grant_id,
    output logic                         o_timeout
);
    localparam int WD_W  = clog2_min1(TIMEOUT_CYC);
    localparam int GAP_W = clog2_min1(GAP_CYC + 1);

    arb_state_t       state;
    logic             lock;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic             win_any;
    logic [WD_W-1:0]  wdog;
    logic [GAP_W-1:0] gap_cnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req          (i_req_valid),
        .i_mask_en      (lock),
        .i_mask_idx     (o_grant_id),
        .i_ptr          (ptr),
        .o_grant_onehot (win_onehot),
        .o_grant_idx    (win_idx),
        .o_any          (win_any)
    );

    // ready is gated by reset too, so it reads 0 while the reset net is low
    assign o_req_ready = (state == IDLE && i_aresetn) ? win_onehot : '0;
    assign o_busy      = state != IDLE || lock;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state      <= IDLE;
            lock       <= 1'b0;
            ptr        <= '0;
            wdog       <= '0;
            gap_cnt    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_grant_id <= '0;
            o_timeout  <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: if (win_any) begin
                    o_tx_data  <= i_req_data[UART_DATA_W*win_idx +: UART_DATA_W];
                    o_grant_id <= win_idx;
                    ptr        <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    lock       <= ~i_req_last[win_idx];
                    o_tx_start <= 1'b1;
                    wdog       <= '0;
                    state      <= SEND;
                end
                SEND: if (i_tx_done) begin
                    o_tx_start <= 1'b0;
                    gap_cnt    <= '0;
                    state      <= GAP;
                end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    o_tx_start <= 1'b0;
                    o_timeout  <= 1'b1;
                    lock       <= 1'b0;
                    gap_cnt    <= '0;
                    state      <= GAP;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                GAP: if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= IDLE;
                     else gap_cnt <= gap_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX transmitter (8N1, start sampled only on its baud tick while idle) between N_REQ byte requesters.
- Round-robin arbitration with optional packet lock, so a multi-byte message from one requester is not interleaved with bytes from others.
- Sequences the transmitter: holds start/data stable for the whole frame, waits for the done pulse, enforces an inter-frame gap, and aborts on a watchdog timeout.
- Sits between protocol/host logic and UART_TX; its o_tx_* outputs connect directly to UART_TX i_tx_start/i_tx_data, and i_tx_done connects to UART_TX o_tx_done.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- GAP_CYC, 1, idle clock cycles after done before the next grant (>=1)
- TIMEOUT_CYC, 20000, cycles in SEND without done before abort (> 11 bit-times at the configured baud)

Ports:
- i_clk  in  1  clock
- i_aresetn  in  1  reset, asynchronous, active-low
- i_req_valid  in  N_REQ  per-requester byte valid
- i_req_data  in  8*N_REQ  per-requester byte; requester k occupies bits [8k+7:8k]
- i_req_last  in  N_REQ  byte is last of packet (1 = single-byte or end of packet)
- o_req_ready  out  N_REQ  accept strobe; transfer when valid&ready
- o_tx_start  out  1  to UART_TX i_tx_start
- o_tx_data  out  8  to UART_TX i_tx_data
- i_tx_done  in  1  from UART_TX o_tx_done (one-cycle pulse)
- o_busy  out  1  state != IDLE or lock held
- o_grant_id  out  $clog2(N_REQ)  owner of current/last frame
- o_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: o_req_ready=0, o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_grant_id=0, o_timeout=0. Internal state: rr pointer=0, lock=0, state=IDLE.
- States: IDLE, SEND, GAP.
- IDLE:
  - Candidates are all valid requesters; if lock=1, the only candidate is owner.
  - Round-robin search starts at last_grant+1 (mod N_REQ).
  - o_req_ready is combinational: one-hot on the winner, only in IDLE, only when that requester is valid. Never more than one bit high.
  - On transfer: register data into o_tx_data, grant into o_grant_id, update last_grant, next state SEND.
  - On transfer, the lock updates from the transferred byte's last: lock=~last, owner=grant.
- SEND:
  - o_tx_start=1 and o_tx_data held constant for the whole state. UART_TX ignores start outside its idle state, so start stays high until done.
  - On i_tx_done: o_tx_start=0 in the next cycle, next state GAP.
  - Start must drop before the next baud tick. This holds because done follows the stop tick by 1 cycle.
  - Watchdog counter is cleared on SEND entry and increments each SEND cycle. When it reaches TIMEOUT_CYC-1 without done: pulse o_timeout, o_tx_start=0, lock=0, next state GAP.
- GAP: count GAP_CYC cycles, then return to IDLE. o_req_ready=0 throughout.
- Lock held with owner not valid: the arbiter waits indefinitely; other requesters are starved by design. Reset is the only other release.
- i_tx_done outside SEND is ignored.
- Simultaneous done and timeout in the same cycle: done wins, no o_timeout pulse.
- Reset mid-operation: all outputs return to reset values immediately. UART_TX is reset on the same net.
- Latency: valid in IDLE → o_tx_start=1 on the next clock edge.
- Data path widths: all data paths are 8-bit. Counter widths are $clog2 of TIMEOUT_CYC and GAP_CYC+1.

Decomposition:
- uart_pkg:
  - arb_state_t enum {IDLE, SEND, GAP}
  - localparam UART_DATA_W=8
  - function clog2_min1
- Sub-module rr_arbiter (N_REQ, i_req, i_mask_en, i_mask_idx, i_ptr, o_grant_onehot, o_grant_idx, o_any) is purely combinational.
- FSM, watchdog and gap counters stay in uart_tx_arbiter.

Test Plan:
- Req0 valid, data 8'hA5, last=1, with a real UART_TX at CLK_FREQ/BAUD=868 → ready0 for 1 cycle; o_tx_start high with o_tx_data=8'hA5 until done; serial line carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); o_grant_id=0.
- Req0..3 all valid, single-byte, data 8'h10..8'h13 → frames emitted in order 8'h10, 8'h11, 8'h12, 8'h13; second round starts at req0 again; at most one ready bit per cycle.
- Req1 sends 3-byte packet (last=0,0,1) while req2 is continuously valid → bytes from req1 are contiguous; req2 is granted only after the last=1 byte; o_busy stays high throughout.
- i_tx_done tied 0, TIMEOUT_CYC=100 → o_timeout pulses exactly 100 cycles after SEND entry; o_tx_start=0 next cycle; lock cleared; next requester served after GAP.
- Assert i_aresetn low mid-frame (during DATA bits) → all outputs at reset values in the same cycle; after release a new request is granted starting from req0.
- GAP_CYC=5, two back-to-back single-byte requests → exactly 5 cycles with o_tx_start=0 and no ready between done and the second grant's ready.
